// File: rtl/decimation_peak_counter_if.sv
// Capture-path bus between the ADC input register and the capture RAM
// write logic.
//   Deicimation_IN : decimation factor D (window = D+1 samples)
//   Mode           : 0 = plain decimation, 1 = peak detect
//   Start_WR       : run enable, 0 = idle/reload
//   DATA_IN        : ADC sample, valid every cycle
//   EN             : write strobe, one cycle per output sample
//   CLK_EN         : EN delayed one cycle (address increment)
//   DATA_OUT       : sample accompanying EN
//   Min_Max_Sel    : 0 = min/plain sample, 1 = max sample
// master = sample source / RAM side, slave = the counter.
interface decimation_peak_counter_if #(
  parameter int CNT_W  = 24,
  parameter int DATA_W = 8
);
  logic [CNT_W-1:0]  Deicimation_IN;
  logic              Mode;
  logic              Start_WR;
  logic [DATA_W-1:0] DATA_IN;
  logic              EN;
  logic              CLK_EN;
  logic [DATA_W-1:0] DATA_OUT;
  logic              Min_Max_Sel;

  modport master (
    output Deicimation_IN, Mode, Start_WR, DATA_IN,
    input  EN, CLK_EN, DATA_OUT, Min_Max_Sel
  );

  modport slave (
    input  Deicimation_IN, Mode, Start_WR, DATA_IN,
    output EN, CLK_EN, DATA_OUT, Min_Max_Sel
  );
endinterface

// File: rtl/decimation_peak_counter.sv
// Decimating capture counter with optional peak detect.
// Mode 0 emits the last sample of every (D+1)-sample window. Mode 1 emits
// the window minimum and then the window maximum on consecutive cycles, so
// short glitches survive decimation.
// Ports:
//   CLK   : sample clock, rising edge
//   RST_N : asynchronous active-low reset
//   bus   : decimation_peak_counter_if.slave (see interface header)
module decimation_peak_counter #(
  parameter int CNT_W      = 24,
  parameter int DATA_W     = 8,
  parameter int SIGNED_CMP = 0
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  decimation_peak_counter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, EMIT_MAX} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  d_lat, d_lat_n, cnt, cnt_n, d_eff, cnt_cur;
  logic              mode_lat, mode_lat_n;
  logic [DATA_W-1:0] run_min, run_min_n, run_max, run_max_n;
  logic [DATA_W-1:0] dout, dout_n;
  logic              en, en_n, sel, sel_n, clk_en;
  logic              last, first;

  function automatic logic lt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    if (SIGNED_CMP != 0) return $signed(a) < $signed(b);
    else                 return a < b;
  endfunction

  // Peak mode needs at least two samples per window (min then max).
  assign d_eff = (mode_lat && d_lat == '0) ? CNT_W'(1) : d_lat;
  // On the first run edge the count comes straight from the latched factor.
  assign cnt_cur = (state == IDLE) ? d_eff : cnt;
  assign last    = (cnt_cur == '0);
  // In peak mode a window starts on the first run edge and on every
  // EMIT_MAX edge; plain mode never looks at this.
  assign first   = (state != RUN);

  always_comb begin
    state_n    = state;
    d_lat_n    = d_lat;
    mode_lat_n = mode_lat;
    cnt_n      = cnt;
    run_min_n  = run_min;
    run_max_n  = run_max;
    dout_n     = dout;
    en_n       = 1'b0;
    sel_n      = sel;
    if (!bus.Start_WR) begin
      state_n    = IDLE;
      d_lat_n    = bus.Deicimation_IN;
      mode_lat_n = bus.Mode;
      cnt_n      = d_eff;
      sel_n      = 1'b0;
    end else begin
      state_n = RUN;
      cnt_n   = last ? d_eff : cnt_cur - CNT_W'(1);
      if (mode_lat) begin
        // Held max goes out while this edge's sample opens the next window.
        if (state == EMIT_MAX) begin
          dout_n = run_max;
          en_n   = 1'b1;
          sel_n  = 1'b1;
        end
        if (first) begin
          run_min_n = bus.DATA_IN;
          run_max_n = bus.DATA_IN;
        end else begin
          run_min_n = lt(bus.DATA_IN, run_min) ? bus.DATA_IN : run_min;
          run_max_n = lt(run_max, bus.DATA_IN) ? bus.DATA_IN : run_max;
        end
        if (last) begin
          dout_n  = run_min_n;
          en_n    = 1'b1;
          sel_n   = 1'b0;
          state_n = EMIT_MAX;
        end
      end else if (last) begin
        dout_n = bus.DATA_IN;
        en_n   = 1'b1;
        sel_n  = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      d_lat    <= '0;
      mode_lat <= 1'b0;
      cnt      <= '0;
      run_min  <= '0;
      run_max  <= '0;
      dout     <= '0;
      en       <= 1'b0;
      sel      <= 1'b0;
      clk_en   <= 1'b0;
    end else begin
      state    <= state_n;
      d_lat    <= d_lat_n;
      mode_lat <= mode_lat_n;
      cnt      <= cnt_n;
      run_min  <= run_min_n;
      run_max  <= run_max_n;
      dout     <= dout_n;
      en       <= en_n;
      sel      <= sel_n;
      clk_en   <= en;
    end
  end

  assign bus.EN          = en;
  assign bus.CLK_EN      = clk_en;
  assign bus.DATA_OUT    = dout;
  assign bus.Min_Max_Sel = sel;

endmodule

// File: tb/tb_decimation_peak_counter.sv
module tb_decimation_peak_counter;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  logic [23:0] d_in;
  logic        mode_in, start;
  logic [7:0]  din;

  // inst 0: unsigned, CNT_W=24; inst 1: signed, CNT_W=4 (D=15 is all-ones)
  decimation_peak_counter_if #(.CNT_W(24), .DATA_W(8)) if0 ();
  decimation_peak_counter_if #(.CNT_W(4),  .DATA_W(8)) if1 ();

  assign if0.Deicimation_IN = d_in;
  assign if0.Mode           = mode_in;
  assign if0.Start_WR       = start;
  assign if0.DATA_IN        = din;
  assign if1.Deicimation_IN = d_in[3:0];
  assign if1.Mode           = mode_in;
  assign if1.Start_WR       = start;
  assign if1.DATA_IN        = din;

  decimation_peak_counter #(.CNT_W(24), .DATA_W(8), .SIGNED_CMP(0)) dut0 (
    .CLK(CLK), .RST_N(RST_N), .bus(if0));
  decimation_peak_counter #(.CNT_W(4), .DATA_W(8), .SIGNED_CMP(1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .bus(if1));

  typedef struct {int e; logic [7:0] d; logic s;} exp_t;
  exp_t q[2][$];
  logic [7:0] smp[$];
  int ecnt = 0, errors = 0, checks = 0;
  logic exp_prev[2] = '{1'b0, 1'b0};

  always @(posedge CLK) ecnt = ecnt + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, ecnt);
    end
  endtask

  // Monitor: compares every presented strobe against the scoreboard.
  always @(negedge CLK) begin
    logic en_s[2], cen_s[2], sel_s[2];
    logic [7:0] d_s[2];
    en_s  = '{if0.EN, if1.EN};
    cen_s = '{if0.CLK_EN, if1.CLK_EN};
    sel_s = '{if0.Min_Max_Sel, if1.Min_Max_Sel};
    d_s   = '{if0.DATA_OUT, if1.DATA_OUT};
    for (int k = 0; k < 2; k++) begin
      logic exp_now;
      exp_t it;
      exp_now = (q[k].size() > 0) && (q[k][0].e == ecnt);
      chk($sformatf("en%0d", k), int'(en_s[k]), int'(exp_now));
      chk($sformatf("clk_en%0d", k), int'(cen_s[k]), int'(exp_prev[k]));
      if (exp_now) begin
        it = q[k].pop_front();
        if (en_s[k]) begin
          chk($sformatf("data%0d", k), int'(d_s[k]), int'(it.d));
          chk($sformatf("sel%0d", k), int'(sel_s[k]), int'(it.s));
        end
      end
      exp_prev[k] = exp_now;
    end
  end

  function automatic int sval(input int k, input logic [7:0] x);
    return (k == 1) ? int'($signed(x)) : int'(x);
  endfunction

  // Reference: split the run's samples into windows and list the strobes.
  task automatic model(input int D, input int mode, input int n, input int e0);
    int deff, w;
    deff = (mode == 1 && D == 0) ? 1 : D;
    w = deff + 1;
    for (int k = 0; k < 2; k++)
      for (int st = 0; st + deff < n; st += w) begin
        int l;
        l = st + deff;
        if (mode == 0) q[k].push_back('{e0 + l, smp[l], 1'b0});
        else begin
          logic [7:0] mn, mx;
          mn = smp[st]; mx = smp[st];
          for (int i = st + 1; i <= l; i++) begin
            if (sval(k, smp[i]) < sval(k, mn)) mn = smp[i];
            if (sval(k, smp[i]) > sval(k, mx)) mx = smp[i];
          end
          q[k].push_back('{e0 + l, mn, 1'b0});
          if (l + 1 < n) q[k].push_back('{e0 + l + 1, mx, 1'b1});
        end
      end
  endtask

  // smp must hold at least n samples. D/Mode inputs wander mid-run.
  task automatic run(input int D, input int mode, input int n);
    d_in = 24'(D); mode_in = mode[0]; start = 1'b0;
    repeat (3) begin @(posedge CLK); #1; end
    model(D, mode, n, ecnt + 1);
    for (int i = 0; i < n; i++) begin
      start = 1'b1;
      din = smp[i];
      if (i > 0) begin
        d_in = 24'($urandom_range(0, 15));
        mode_in = 1'($urandom);
      end
      @(posedge CLK); #1;
    end
    start = 1'b0;
  endtask

  task automatic fill_rand(input int n);
    smp.delete();
    for (int i = 0; i < n; i++) smp.push_back(8'($urandom));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    RST_N = 1'b0; start = 1'b1; d_in = '0; mode_in = 1'b0; din = '0;
    for (int i = 0; i < 5; i++) begin
      din = 8'($urandom);
      @(posedge CLK); #1;
      chk("rst_en", int'(if0.EN | if1.EN), 0);
      chk("rst_clk_en", int'(if0.CLK_EN | if1.CLK_EN), 0);
      chk("rst_data", int'(if0.DATA_OUT | if1.DATA_OUT), 0);
      chk("rst_sel", int'(if0.Min_Max_Sel | if1.Min_Max_Sel), 0);
    end
    start = 1'b0;
    RST_N = 1'b1;
    repeat (2) begin
      @(posedge CLK); #1;
      chk("post_rst_en", int'(if0.EN | if1.EN), 0);
      chk("post_rst_data", int'(if0.DATA_OUT | if1.DATA_OUT), 0);
    end

    // mode 0, D=3, ramp: strobes carry 3, 7, 11
    smp.delete();
    for (int i = 0; i < 14; i++) smp.push_back(8'(i));
    run(3, 0, 14);
    // mode 0, D=0: continuous strobe
    fill_rand(10); run(0, 0, 10);
    // mode 1, D=4 with a known window, then a second random window
    fill_rand(11);
    smp[0] = 8'd10; smp[1] = 8'd200; smp[2] = 8'd3; smp[3] = 8'd50; smp[4] = 8'd7;
    run(4, 1, 11);
    // mode 1, D=2: signed vs unsigned extremes differ
    fill_rand(4);
    smp[0] = 8'h7F; smp[1] = 8'h80; smp[2] = 8'h01;
    run(2, 1, 4);
    // mode 1, D=0 behaves as D=1
    fill_rand(8); run(0, 1, 8);
    // Start_WR dropped on the EMIT_MAX edge: max strobe discarded
    fill_rand(4); run(3, 1, 4);
    // D=15 (all-ones for the 4-bit instance), both modes
    fill_rand(40); run(15, 1, 40);
    fill_rand(40); run(15, 0, 40);
    // random runs
    for (int r = 0; r < 20; r++) begin
      int D, m, n;
      D = $urandom_range(0, 15);
      m = $urandom_range(0, 1);
      n = $urandom_range(1, 60);
      fill_rand(n);
      run(D, m, n);
    end

    repeat (5) begin @(posedge CLK); #1; end
    chk("q0_empty", q[0].size(), 0);
    chk("q1_empty", q[1].size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
